// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states, ALU op
// codes, opcode constants, op classes and the datapath mux select codes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StBranch = 3'd5,
    StTrap   = 3'd6
  } ctrl_state_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_AND  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLL  = 3'd3,
    ALU_SRA  = 3'd4,
    ALU_SUB  = 3'd5,
    ALU_JALR = 3'd6,
    ALU_ZERO = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui
  } op_class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_TRAP   = 2'd2;

  // Branch resolution from rs1-rs2 flags; signed overflow is deliberately not corrected.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic msb);
    logic taken;
    unique case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = msb;
      F3_BGE:  taken = ~msb;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct3/funct7 -> op class, ALU op,
// immediate format and illegal flag. Only the ops the shared ALU can execute are legal.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output op_class_e  cls_o,
  output alu_op_e    alu_op_o,
  output logic [2:0] imm_sel_o,
  output logic       illegal_o
);

  logic f7_zero, f7_alt;
  assign f7_zero = (funct7_i == 7'h00);
  assign f7_alt  = (funct7_i == 7'h20);

  // Classify the instruction and flag encodings the datapath cannot execute.
  always_comb begin
    cls_o     = ClsR;
    alu_op_o  = ALU_ADD;
    imm_sel_o = IMM_I;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        cls_o = ClsR;
        case (funct3_i)
          3'b000: begin
            if (f7_zero)     alu_op_o = ALU_ADD;
            else if (f7_alt) alu_op_o = ALU_SUB;
            else             illegal_o = 1'b1;
          end
          3'b001: begin alu_op_o = ALU_SLL; illegal_o = ~f7_zero; end
          3'b100: begin alu_op_o = ALU_XOR; illegal_o = ~f7_zero; end
          3'b101: begin alu_op_o = ALU_SRA; illegal_o = ~f7_alt;  end
          3'b111: begin alu_op_o = ALU_AND; illegal_o = ~f7_zero; end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_I: begin
        cls_o = ClsI;
        case (funct3_i)
          3'b000: alu_op_o = ALU_ADD;
          3'b100: alu_op_o = ALU_XOR;
          3'b111: alu_op_o = ALU_AND;
          3'b001: begin alu_op_o = ALU_SLL; illegal_o = ~f7_zero; end
          3'b101: begin alu_op_o = ALU_SRA; illegal_o = ~f7_alt;  end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_LOAD: begin
        cls_o     = ClsLoad;
        illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
      end
      OP_STORE: begin
        cls_o     = ClsStore;
        imm_sel_o = IMM_S;
        illegal_o = funct3_i[2] || (funct3_i[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        cls_o     = ClsBranch;
        imm_sel_o = IMM_B;
        alu_op_o  = ALU_SUB;
        // No unsigned compare flag, so bltu/bgeu are rejected.
        illegal_o = (funct3_i[2:1] == 2'b01) || (funct3_i[2:1] == 2'b11);
      end
      OP_JAL: begin
        cls_o     = ClsJal;
        imm_sel_o = IMM_J;
      end
      OP_JALR: begin
        cls_o     = ClsJalr;
        alu_op_o  = ALU_JALR;
        illegal_o = (funct3_i != 3'b000);
      end
      OP_LUI: begin
        cls_o     = ClsLui;
        imm_sel_o = IMM_U;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_control_fsm.sv
// Multi-cycle RV32I control FSM driving the shared ALU, memories, register file and PC.
// Optional illegal-instruction trap state is built when RV_CTRL_ILLEGAL_TRAP_EN is defined;
// otherwise illegal instructions retire as a NOP and trap_o stays low.
module rv_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned ALU_SEL_W   = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  output logic                 imem_req_o,
  input  logic                 imem_ack_i,
  input  logic [31:0]          instr_i,
  output logic                 ir_we_o,
  output logic [ALU_SEL_W-1:0] alu_sel_o,
  input  logic                 alu_msb_i,
  input  logic                 alu_zero_i,
  output logic                 alu_src_a_o,
  output logic                 alu_src_b_o,
  output logic [2:0]           imm_sel_o,
  output logic                 tgt_we_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  input  logic                 dmem_ack_i,
  output logic                 rf_we_o,
  output logic [1:0]           wb_sel_o,
  output logic                 pc_we_o,
  output logic [1:0]           pc_sel_o,
  output logic                 mem_err_o,
  output logic                 trap_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Only the decode-relevant fields are kept: {funct7, funct3, opcode}.
  logic [16:0]     ir_q;

  op_class_e  dec_cls;
  alu_op_e    dec_alu;
  logic [2:0] dec_imm;
  logic       dec_illegal;
  alu_op_e    alu_sel;
  logic       timeout;
  logic       unused_instr;

  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};
  assign timeout      = (cnt_q == CntW'(MEM_TIMEOUT));
  assign alu_sel_o    = ALU_SEL_W'(alu_sel);

  rv_ctrl_decode u_decode (
    .opcode_i  (ir_q[6:0]),
    .funct3_i  (ir_q[9:7]),
    .funct7_i  (ir_q[16:10]),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu),
    .imm_sel_o (dec_imm),
    .illegal_o (dec_illegal)
  );

  // State, wait counter and instruction-field register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ir_we_o) ir_q <= {instr_i[31:25], instr_i[14:12], instr_i[6:0]};
    end
  end

  // Next-state and output decode; everything stays 0 while reset is asserted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    alu_sel     = ALU_ADD;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    imm_sel_o   = IMM_I;
    tgt_we_o    = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = WB_ALU;
    pc_we_o     = 1'b0;
    pc_sel_o    = PC_PLUS4;
    mem_err_o   = 1'b0;
    trap_o      = 1'b0;

    if (reset_i) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          // The request drops in the timeout cycle; a late ack there still wins.
          imem_req_o = ~timeout;
          if (imem_ack_i) begin
            ir_we_o = 1'b1;
            state_d = StDecode;
          end else if (timeout) begin
            mem_err_o = 1'b1;
            pc_we_o   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDecode: begin
          // Precompute PC+imm into the target register for branches and jal.
          alu_src_a_o = 1'b1;
          alu_src_b_o = 1'b1;
          tgt_we_o    = 1'b1;
          imm_sel_o   = dec_imm;
          if (dec_illegal) begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
            state_d = StTrap;
`else
            pc_we_o = 1'b1;
            state_d = StFetch;
`endif
          end else begin
            state_d = StExec;
          end
        end
        StExec: begin
          imm_sel_o = dec_imm;
          unique case (dec_cls)
            ClsR:      begin alu_sel = dec_alu; state_d = StWb; end
            ClsI:      begin alu_sel = dec_alu; alu_src_b_o = 1'b1; state_d = StWb; end
            ClsLoad,
            ClsStore:  begin alu_src_b_o = 1'b1; state_d = StMem; end
            ClsBranch: begin alu_sel = ALU_SUB; state_d = StBranch; end
            ClsJal:    state_d = StWb;
            ClsJalr: begin
              alu_sel     = ALU_JALR;
              alu_src_b_o = 1'b1;
              tgt_we_o    = 1'b1;
              state_d     = StWb;
            end
            ClsLui:    begin alu_src_b_o = 1'b1; state_d = StWb; end
            default:   state_d = StFetch;
          endcase
        end
        StMem: begin
          dmem_req_o = ~timeout;
          dmem_we_o  = ~timeout & (dec_cls == ClsStore);
          if (dmem_ack_i) begin
            if (dec_cls == ClsStore) begin
              pc_we_o = 1'b1;
              state_d = StFetch;
            end else begin
              state_d = StWb;
            end
          end else if (timeout) begin
            mem_err_o = 1'b1;
            pc_we_o   = 1'b1;
            state_d   = StFetch;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWb: begin
          rf_we_o = 1'b1;
          pc_we_o = 1'b1;
          if (dec_cls == ClsLoad) wb_sel_o = WB_MEM;
          if (dec_cls == ClsJal || dec_cls == ClsJalr) begin
            wb_sel_o = WB_PC4;
            pc_sel_o = PC_TARGET;
          end
          state_d = StFetch;
        end
        StBranch: begin
          // Keep the compare on the ALU so the flags are valid this cycle.
          alu_sel  = ALU_SUB;
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken(ir_q[9:7], alu_zero_i, alu_msb_i) ? PC_TARGET : PC_PLUS4;
          state_d  = StFetch;
        end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        StTrap: begin
          trap_o   = 1'b1;
          pc_we_o  = 1'b1;
          pc_sel_o = PC_TRAP;
          state_d  = StFetch;
        end
`endif
        default: state_d = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_control_fsm.sv
// Directed-vector bench for rv_control_fsm: each cycle the full output bundle is
// compared against a hand-built expectation.
module tb_rv_control_fsm;

  localparam logic [2:0] I_IMM = 3'd0;
  localparam logic [2:0] S_IMM = 3'd1;
  localparam logic [2:0] B_IMM = 3'd2;
  localparam logic [2:0] J_IMM = 3'd3;
  localparam logic [2:0] U_IMM = 3'd4;

  logic        clk_i = 1'b0;
  logic        reset_i, imem_ack_i, alu_msb_i, alu_zero_i, dmem_ack_i;
  logic [31:0] instr_i;
  logic        imem_req_o, ir_we_o, alu_src_a_o, alu_src_b_o, tgt_we_o;
  logic        dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, mem_err_o, trap_o;
  logic [2:0]  alu_sel_o, imm_sel_o;
  logic [1:0]  wb_sel_o, pc_sel_o;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic [2:0] alu_sel;
    logic       src_a;
    logic       src_b;
    logic [2:0] imm_sel;
    logic       tgt_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       mem_err;
    logic       trap;
  } outs_t;

  outs_t got;
  assign got = {imem_req_o, ir_we_o, alu_sel_o, alu_src_a_o, alu_src_b_o, imm_sel_o,
                tgt_we_o, dmem_req_o, dmem_we_o, rf_we_o, wb_sel_o, pc_we_o, pc_sel_o,
                mem_err_o, trap_o};

  int unsigned n_vec;
  int unsigned n_miss;

  rv_control_fsm #(
    .ALU_SEL_W   (3),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .imem_req_o  (imem_req_o),
    .imem_ack_i  (imem_ack_i),
    .instr_i     (instr_i),
    .ir_we_o     (ir_we_o),
    .alu_sel_o   (alu_sel_o),
    .alu_msb_i   (alu_msb_i),
    .alu_zero_i  (alu_zero_i),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .imm_sel_o   (imm_sel_o),
    .tgt_we_o    (tgt_we_o),
    .dmem_req_o  (dmem_req_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_ack_i  (dmem_ack_i),
    .rf_we_o     (rf_we_o),
    .wb_sel_o    (wb_sel_o),
    .pc_we_o     (pc_we_o),
    .pc_sel_o    (pc_sel_o),
    .mem_err_o   (mem_err_o),
    .trap_o      (trap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance to just after the next edge.
  task automatic cyc(input string tag, input outs_t e);
    #1;
    check(tag, 32'(got), 32'(e));
    @(posedge clk_i);
    #1;
  endtask

  function automatic outs_t o_fetch(input logic ack);
    outs_t o = '0;
    o.imem_req = 1'b1;
    o.ir_we    = ack;
    return o;
  endfunction

  function automatic outs_t o_dec(input logic [2:0] imm);
    outs_t o = '0;
    o.src_a   = 1'b1;
    o.src_b   = 1'b1;
    o.tgt_we  = 1'b1;
    o.imm_sel = imm;
    return o;
  endfunction

  function automatic outs_t o_exec(input logic [2:0] alu, input logic srcb,
                                   input logic [2:0] imm, input logic tgt);
    outs_t o = '0;
    o.alu_sel = alu;
    o.src_b   = srcb;
    o.imm_sel = imm;
    o.tgt_we  = tgt;
    return o;
  endfunction

  function automatic outs_t o_mem(input logic we);
    outs_t o = '0;
    o.dmem_req = 1'b1;
    o.dmem_we  = we;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic [1:0] wb, input logic [1:0] pc);
    outs_t o = '0;
    o.rf_we  = 1'b1;
    o.pc_we  = 1'b1;
    o.wb_sel = wb;
    o.pc_sel = pc;
    return o;
  endfunction

  function automatic outs_t o_pc(input logic [1:0] pc, input logic [2:0] alu);
    outs_t o = '0;
    o.pc_we   = 1'b1;
    o.pc_sel  = pc;
    o.alu_sel = alu;
    return o;
  endfunction

  // Fetch with an immediate ack, then the decode cycle.
  task automatic front(input string tag, input logic [31:0] ins, input logic [2:0] imm);
    instr_i    = ins;
    imem_ack_i = 1'b1;
    cyc({tag, "/fetch"}, o_fetch(1'b1));
    imem_ack_i = 1'b0;
    instr_i    = 32'h0;
    cyc({tag, "/decode"}, o_dec(imm));
  endtask

  task automatic alu_op(input string tag, input logic [31:0] ins, input logic [2:0] alu,
                        input logic srcb);
    front(tag, ins, I_IMM);
    cyc({tag, "/exec"}, o_exec(alu, srcb, I_IMM, 1'b0));
    cyc({tag, "/wb"}, o_wb(2'd0, 2'd0));
  endtask

  task automatic branch(input string tag, input logic [31:0] ins, input logic msb,
                        input logic zero, input logic taken);
    front(tag, ins, B_IMM);
    alu_msb_i  = msb;
    alu_zero_i = zero;
    cyc({tag, "/exec"}, o_exec(3'd5, 1'b0, B_IMM, 1'b0));
    cyc({tag, "/branch"}, o_pc({1'b0, taken}, 3'd5));
    alu_msb_i  = 1'b0;
    alu_zero_i = 1'b0;
  endtask

  task automatic lw_to_mem(input string tag);
    front(tag, 32'h0000A183, I_IMM);
    cyc({tag, "/exec"}, o_exec(3'd0, 1'b1, I_IMM, 1'b0));
  endtask

  task automatic illegal(input string tag, input logic [31:0] ins);
    outs_t e;
    instr_i    = ins;
    imem_ack_i = 1'b1;
    cyc({tag, "/fetch"}, o_fetch(1'b1));
    imem_ack_i = 1'b0;
    e = o_dec(I_IMM);
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    cyc({tag, "/decode"}, e);
    e = o_pc(2'd2, 3'd0);
    e.trap = 1'b1;
    cyc({tag, "/trap"}, e);
`else
    e.pc_we = 1'b1;
    cyc({tag, "/decode_nop"}, e);
`endif
    cyc({tag, "/refetch"}, o_fetch(1'b0));
  endtask

  initial begin
    outs_t e;
    n_vec      = 0;
    n_miss     = 0;
    reset_i    = 1'b1;
    imem_ack_i = 1'b0;
    instr_i    = 32'h0;
    alu_msb_i  = 1'b0;
    alu_zero_i = 1'b0;
    dmem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    cyc("reset", '0);
    reset_i = 1'b0;
    cyc("idle_fetch", o_fetch(1'b0));

    alu_op("add",  32'h002081B3, 3'd0, 1'b0);
    alu_op("sub",  32'h402081B3, 3'd5, 1'b0);
    alu_op("srai", 32'h4030D193, 3'd4, 1'b1);
    alu_op("and",  32'h0020F1B3, 3'd1, 1'b0);
    alu_op("xori", 32'h0040C193, 3'd2, 1'b1);
    alu_op("sll",  32'h002091B3, 3'd3, 1'b0);

    branch("blt_t",  32'h0020C463, 1'b1, 1'b0, 1'b1);
    branch("blt_n",  32'h0020C463, 1'b0, 1'b1, 1'b0);
    branch("beq_t",  32'h00208463, 1'b0, 1'b1, 1'b1);
    branch("beq_n",  32'h00208463, 1'b1, 1'b0, 1'b0);
    branch("bne_n",  32'h00209463, 1'b0, 1'b1, 1'b0);
    branch("bne_t",  32'h00209463, 1'b1, 1'b0, 1'b1);
    branch("bge_t",  32'h0020D463, 1'b0, 1'b0, 1'b1);
    branch("bge_n",  32'h0020D463, 1'b1, 1'b0, 1'b0);

    // Load with dmem_ack on the third MEM cycle.
    lw_to_mem("lw");
    cyc("lw/mem1", o_mem(1'b0));
    cyc("lw/mem2", o_mem(1'b0));
    dmem_ack_i = 1'b1;
    cyc("lw/mem3", o_mem(1'b0));
    dmem_ack_i = 1'b0;
    cyc("lw/wb", o_wb(2'd1, 2'd0));

    // Store acked in its first MEM cycle retires from MEM.
    front("sw", 32'h0020A023, S_IMM);
    cyc("sw/exec", o_exec(3'd0, 1'b1, S_IMM, 1'b0));
    dmem_ack_i = 1'b1;
    e = o_mem(1'b1);
    e.pc_we = 1'b1;
    cyc("sw/mem", e);
    dmem_ack_i = 1'b0;
    cyc("sw/refetch", o_fetch(1'b0));

    front("jal", 32'h008000EF, J_IMM);
    cyc("jal/exec", o_exec(3'd0, 1'b0, J_IMM, 1'b0));
    cyc("jal/wb", o_wb(2'd2, 2'd1));
    front("jalr", 32'h000080E7, I_IMM);
    cyc("jalr/exec", o_exec(3'd6, 1'b1, I_IMM, 1'b1));
    cyc("jalr/wb", o_wb(2'd2, 2'd1));
    front("lui", 32'h123451B7, U_IMM);
    cyc("lui/exec", o_exec(3'd0, 1'b1, U_IMM, 1'b0));
    cyc("lui/wb", o_wb(2'd0, 2'd0));

    // dmem never acks: 16 request cycles, then the error cycle.
    lw_to_mem("lw_to");
    for (int k = 0; k < 16; k++) cyc("lw_to/mem_wait", o_mem(1'b0));
    e = o_pc(2'd0, 3'd0);
    e.mem_err = 1'b1;
    cyc("lw_to/mem_err", e);
    cyc("lw_to/refetch", o_fetch(1'b0));

    // Ack landing in the timeout cycle is a normal completion.
    lw_to_mem("lw_late");
    for (int k = 0; k < 16; k++) cyc("lw_late/mem_wait", o_mem(1'b0));
    dmem_ack_i = 1'b1;
    cyc("lw_late/ack_at_to", '0);
    dmem_ack_i = 1'b0;
    cyc("lw_late/wb", o_wb(2'd1, 2'd0));

    // Reset while in MEM, then an instruction fetch that never acks.
    lw_to_mem("lw_rst");
    cyc("lw_rst/mem1", o_mem(1'b0));
    reset_i = 1'b1;
    cyc("lw_rst/in_reset", '0);
    reset_i = 1'b0;
    for (int k = 0; k < 16; k++) cyc("fetch_to/wait", o_fetch(1'b0));
    e = o_pc(2'd0, 3'd0);
    e.mem_err = 1'b1;
    cyc("fetch_to/mem_err", e);
    cyc("fetch_to/refetch", o_fetch(1'b0));

    illegal("ill_ones", 32'hFFFFFFFF);
    illegal("ill_srl", 32'h0020D1B3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rv_control_fsm.md
Name: rv_control_fsm

Overview:
- Multi-cycle control unit for the RV32I datapath: the driving side of the ALU interface.
- Fetches and decodes one instruction at a time, drives the ALU operation select and operand muxes, and consumes the ALU sign/zero flags to resolve branches.
- Sequences the instruction memory, data memory, register file write and PC update for the single shared ALU.

Parameters:
- ALU_SEL_W, 3, width of the ALU op select.
- MEM_TIMEOUT, 16, max cycles to wait for imem_ack/dmem_ack before aborting.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  instr valid this cycle
- instr  in  32  fetched instruction
- ir_we  out  1  latch instr into instruction register
- alu_sel  out  ALU_SEL_W  op: 0 add, 1 and, 2 xor, 3 sll, 4 sra, 5 sub, 6 jalr target (add, bit0 cleared), 7 zero
- alu_msb  in  1  bit 31 of ALU result
- alu_zero  in  1  ALU result == 0
- alu_src_a  out  1  0 rs1, 1 PC
- alu_src_b  out  1  0 rs2, 1 immediate
- imm_sel  out  3  0 I, 1 S, 2 B, 3 J, 4 U
- tgt_we  out  1  latch ALU result as branch/jump target
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 store, 0 load
- dmem_ack  in  1  data transfer complete
- rf_we  out  1  register file write enable
- wb_sel  out  2  0 ALU, 1 memory, 2 PC+4
- pc_we  out  1  PC update strobe
- pc_sel  out  2  0 PC+4, 1 target register, 2 trap vector
- mem_err  out  1  one-cycle pulse on memory timeout
- trap  out  1  illegal-instruction pulse (feature only)

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP. Encoding is in the package.
- Reset:
  - Next state is FETCH; the timeout counter is cleared.
  - All outputs are 0, including mid-instruction; no partial writeback or memory request survives reset.
- FETCH:
  - imem_req=1 until imem_ack.
  - On imem_ack: ir_we=1, go to DECODE.
- DECODE:
  - alu_src_a=1, alu_src_b=1, alu_sel=0, tgt_we=1 (PC+imm precomputed). imm_sel follows the opcode.
  - Illegal opcode or funct -> TRAP when the feature is enabled; otherwise treated as NOP (pc_we=1, pc_sel=0, -> FETCH).
- EXEC:
  - R/I ALU ops -> WB. R-type sub/sra are selected by funct7 bit 30. I-type has no subi.
  - load/store: alu_sel=0, src_b=1 -> MEM.
  - beq/bne/blt/bge: alu_sel=5, src_b=0 -> BRANCH.
  - jal -> WB.
  - jalr: alu_sel=6, tgt_we=1 -> WB.
  - lui: alu_sel=0, src_a=rs1 forced x0 by decode, src_b=1 (U) -> WB.
- MEM:
  - Hold dmem_req=1; dmem_we=1 for stores.
  - On dmem_ack: loads -> WB; stores -> pc_we=1, pc_sel=0 -> FETCH.
- WB, one cycle:
  - rf_we=1 and pc_we=1.
  - wb_sel is 1 for loads, 2 for jal/jalr, 0 otherwise.
  - pc_sel is 1 for jal/jalr, 0 otherwise.
  - rd==x0 still asserts rf_we; the register file ignores it.
- BRANCH, one cycle:
  - taken = beq:zero, bne:!zero, blt:msb, bge:!msb.
  - pc_we=1, pc_sel = taken ? 1 : 0 -> FETCH.
  - Signed overflow is not corrected: blt/bge are exact only when |rs1-rs2| < 2^31 (decided limitation).
- Latency:
  - R/I type: 4 cycles with 1-cycle fetch.
  - Load: 5 cycles plus extra dmem wait.
  - Store and branch: 4 cycles.
- Timeout:
  - Counter runs while waiting in FETCH or MEM and clears on ack or state change.
  - At MEM_TIMEOUT cycles: mem_err=1 for one cycle, request dropped, pc_we=1, pc_sel=0 -> FETCH.
- An ack arriving in the same cycle as the timeout counts as ack; no error.
- imem_ack/dmem_ack outside FETCH/MEM are ignored.

Optional Feature:
- Macro: RV_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal instruction -> TRAP state for one cycle: trap=1, pc_we=1, pc_sel=2 -> FETCH.
  - No rf/dmem write occurs.
- Undefined:
  - TRAP state is not built and trap is tied 0.
  - Illegal instruction acts as NOP (PC+4).

Decomposition:
- Package rv_ctrl_pkg:
  - state encoding;
  - ALU op codes (ALU_ADD..ALU_ZERO);
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI);
  - imm_sel, wb_sel and pc_sel codes.
- Sub-module rv_ctrl_decode: combinational opcode/funct3/funct7 -> op class, alu_sel, imm_sel, illegal flag. The FSM stays in the top.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_ack in 1st cycle -> alu_sel=0 in EXEC; rf_we=1, wb_sel=0, pc_sel=0 in cycle 4; then FETCH.
- sub (0x402081B3) -> alu_sel=5; srai (0x4030D193) -> alu_sel=4, alu_src_b=1.
- blt (0x0020C463):
  - alu_msb=1 in BRANCH -> pc_we=1, pc_sel=1.
  - alu_msb=0 -> pc_sel=0.
  - beq with alu_zero=1 -> pc_sel=1.
- lw (0x0000A183), dmem_ack after 3 cycles -> dmem_req held 3 cycles, dmem_we=0, then WB with wb_sel=1, rf_we=1.
- dmem_ack never asserted -> mem_err pulses after exactly 16 MEM cycles, pc_we=1, back to FETCH. Separately, reset asserted in MEM -> FETCH next cycle with all outputs 0.
- 0xFFFFFFFF:
  - with macro -> trap=1, pc_sel=2, rf_we=0.
  - without macro -> trap=0, pc_sel=0, pc_we=1, no rf_we.
